// File: rtl/serial_deser.sv
// serial_deser
// Serial-to-parallel deserializer. One bit per cycle arrives on a valid/ready
// serial input. Each group of WIDTH data bits is assembled into a word and
// presented on a registered valid/ready output.
//
// Handshake semantics, both sides: a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer keeps valid and data stable
// until that edge. Ready may depend combinationally on the other side. Here
// sin_ready depends on dout_ready.
//
// Optional feature macro: DESER_PARITY_EN.
//   Defined:   each frame carries WIDTH data bits plus one even-parity bit.
//              par_err is loaded together with dout.
//   Undefined: a frame is WIDTH bits and par_err is tied to 0.
//
// Parameters:
//   WIDTH      data bits per word (2..16)
//   MSB_FIRST  1: the first received bit lands in dout[WIDTH-1]
//              0: the first received bit lands in dout[0]
// Ports:
//   clk         clock, rising edge
//   clr         asynchronous active-high reset
//   sin         serial data bit
//   sin_valid   sin carries a bit this cycle
//   sin_ready   the block accepts the bit this cycle
//   dout        assembled word
//   dout_valid  dout holds an undelivered word
//   dout_ready  the consumer takes dout this cycle
//   par_err     parity error flag, qualified by dout_valid
//   dbg_state   output FSM state (0 = EMPTY, 1 = FULL), for observation only
module serial_deser #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             par_err,
  output logic             dbg_state
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] dout_q;

  logic             last_bit;
  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_d;
  logic             shift_en;

  assign last_bit = (cnt_q == CW'(FRAME - 1));
  // Only the final frame bit can stall: that bit would overwrite a word the
  // consumer has not taken yet.
  assign sin_ready = !(last_bit && dout_valid && !dout_ready);
  assign accept    = sin_valid && sin_ready;
  assign complete  = accept && last_bit;

  // Shift register with the incoming bit applied, in either bit order.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {shift_q[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign shifted = {sin, shift_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef DESER_PARITY_EN
  logic par_q;
  logic par_d;

  // The final frame bit is the parity bit. It is not shifted in, so the
  // completed word is already sitting in the shift register.
  assign shift_en = accept && !last_bit;
  assign word_d   = shift_q;
  assign par_d    = (^shift_q) ^ sin;
  assign par_err  = par_q;
`else
  assign shift_en = accept;
  assign word_d   = shifted;
  assign par_err  = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = (state_q == FULL);
  assign dbg_state  = state_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
`ifdef DESER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt_q <= last_bit ? '0 : cnt_q + CW'(1);
      end
      if (shift_en) begin
        shift_q <= shifted;
      end

      case (state_q)
        EMPTY: begin
          if (complete) begin
            state_q <= FULL;
            dout_q  <= word_d;
`ifdef DESER_PARITY_EN
            par_q   <= par_d;
`endif
          end
        end
        FULL: begin
          // A completing word while FULL implies dout_ready=1, so the old
          // word is consumed and replaced on the same edge.
          if (complete) begin
            dout_q <= word_d;
`ifdef DESER_PARITY_EN
            par_q  <= par_d;
`endif
          end else if (dout_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deser.sv
module tb_serial_deser;

  logic       clk;
  logic       clr;
  logic       sin;
  logic       sin_valid;
  logic       dout_ready;
  logic       sin_ready_a;
  logic       sin_ready_b;
  logic [3:0] dout_a;
  logic [3:0] dout_b;
  logic       dout_valid_a;
  logic       dout_valid_b;
  logic       par_err_a;
  logic       par_err_b;
  logic       dbg_state_a;
  logic       dbg_state_b;

  int n_cmp;
  int n_err;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  serial_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
    .clk        (clk),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready_a),
    .dout       (dout_a),
    .dout_valid (dout_valid_a),
    .dout_ready (dout_ready),
    .par_err    (par_err_a),
    .dbg_state  (dbg_state_a)
  );

  serial_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk        (clk),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready_b),
    .dout       (dout_b),
    .dout_valid (dout_valid_b),
    .dout_ready (dout_ready),
    .par_err    (par_err_b),
    .dbg_state  (dbg_state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  // Sends w[3] first. Appends the even-parity bit when parity frames are built.
  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
`ifdef DESER_PARITY_EN
    send_bit(^w);
`endif
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    clr        = 1'b1;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    tick();

    chk("rst_valid", dout_valid_a, 1'b0);
    chk("rst_dout", dout_a, 4'h0);
    chk("rst_ready", sin_ready_a, 1'b1);

    // Basic word with consumer always ready.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("basic_not_yet", dout_valid_a, 1'b0);
`ifdef DESER_PARITY_EN
    send_bit(1'b1);
    chk("basic_par_not_yet", dout_valid_a, 1'b0);
    send_bit(1'b1);
`else
    send_bit(1'b1);
`endif
    chk("basic_valid", dout_valid_a, 1'b1);
    chk("basic_dout_msb", dout_a, 4'b1011);
    chk("basic_dout_lsb", dout_b, 4'b1101);
    chk("basic_par", par_err_a, 1'b0);
    chk("basic_state", dbg_state_a, 1'b1);
    tick();
    chk("basic_one_cycle", dout_valid_a, 1'b0);

    // Backpressure: hold the first word, stall the final bit of the second.
    dout_ready = 1'b0;
    send_word(4'b1011);
    chk("bp_w1_valid", dout_valid_a, 1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
`ifdef DESER_PARITY_EN
    send_bit(1'b0);
    sin = 1'b0;  // parity of 0110
`else
    sin = 1'b0;
`endif
    sin_valid = 1'b1;
    chk("bp_stall_ready", sin_ready_a, 1'b0);
    chk("bp_hold_dout", dout_a, 4'b1011);
    tick();
    chk("bp_still_stalled", sin_ready_a, 1'b0);
    chk("bp_hold_dout2", dout_a, 4'b1011);
    chk("bp_hold_valid", dout_valid_a, 1'b1);
    dout_ready = 1'b1;
    #1;
    chk("bp_release_ready", sin_ready_a, 1'b1);
    tick();
    sin_valid = 1'b0;
    chk("bp_w2_valid", dout_valid_a, 1'b1);
    chk("bp_w2_dout_msb", dout_a, 4'b0110);
    chk("bp_w2_dout_lsb", dout_b, 4'b0110);
    tick();
    chk("bp_drained", dout_valid_a, 1'b0);

    // dout_ready while EMPTY does nothing; back-to-back words, no stalls.
    send_word(4'b1100);
    chk("b2b_w1", dout_a, 4'b1100);
    chk("b2b_w1_valid", dout_valid_a, 1'b1);
    chk("b2b_ready", sin_ready_a, 1'b1);
    send_word(4'b0011);
    chk("b2b_w2", dout_a, 4'b0011);
    chk("b2b_w2_lsb", dout_b, 4'b1100);
    tick();
    chk("b2b_drained", dout_valid_a, 1'b0);

    // Asynchronous reset mid-frame while a word is held.
    dout_ready = 1'b0;
    send_word(4'b1011);
    send_bit(1'b1); send_bit(1'b1);
    chk("pre_rst_valid", dout_valid_a, 1'b1);
    #2;
    clr = 1'b1;
    #1;
    chk("arst_valid", dout_valid_a, 1'b0);
    chk("arst_dout", dout_a, 4'h0);
    chk("arst_par", par_err_a, 1'b0);
    chk("arst_ready", sin_ready_a, 1'b1);
    chk("arst_dout_lsb", dout_b, 4'h0);
    #1;
    clr = 1'b0;
    dout_ready = 1'b1;
    tick();
    // New frame with a gap between bits.
    send_bit(1'b0); send_bit(1'b0);
    tick();
    chk("gap_not_valid", dout_valid_a, 1'b0);
    send_bit(1'b0); send_bit(1'b1);
`ifdef DESER_PARITY_EN
    send_bit(1'b1);
`endif
    chk("post_rst_valid", dout_valid_a, 1'b1);
    chk("post_rst_dout", dout_a, 4'b0001);
    chk("post_rst_dout_lsb", dout_b, 4'b1000);
    tick();
    chk("post_rst_single", dout_valid_a, 1'b0);

`ifdef DESER_PARITY_EN
    // Bad parity: the word is still delivered, flagged.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("perr_valid", dout_valid_a, 1'b1);
    chk("perr_dout", dout_a, 4'b1011);
    chk("perr_flag", par_err_a, 1'b1);
    tick();
    chk("perr_drained", dout_valid_a, 1'b0);
`else
    chk("nopar_tied", par_err_a, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound the run time.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
